pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised program-counter unit: successor to the combinational PC+4 adder.
- Holds the architectural PC register and computes PC + step.
- Selects next PC by fixed priority across trap, redirect (jump/call/return) and stall.
- Includes an internal return-address stack (RAS) to predict returns. Sits at the head of the fetch stage and drives the instruction-memory address.

Parameters:
- XLEN, 32, PC/address width in bits
- INSTR_BYTES, 4, sequential increment; power of two ≥ 1
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
- RAS_DEPTH, 4, return-address stack entries; power of two ≥ 2

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge)
- stall  in  1  hold PC; blocks sequential advance only
- redir_valid  in  1  non-sequential redirect request this cycle
- redir_kind  in  2  pc_pkg::redir_e: JUMP, CALL, RET
- redir_target  in  XLEN  redirect target (JUMP/CALL; RET fallback)
- trap  in  1  exception/interrupt request
- trap_vector  in  XLEN  trap handler address
- pc  out  XLEN  current PC (registered)
- pc_plus  out  XLEN  pc + INSTR_BYTES (combinational)
- pc_valid  out  1  PC is valid for fetch
- flush  out  1  one-cycle pulse: PC changed non-sequentially
- misalign_err  out  1  one-cycle pulse: redirect target was misaligned
- ras_empty  out  1  RAS holds no entries
- ras_full  out  1  RAS holds RAS_DEPTH entries

Behaviour:
- Reset (rst=0 at edge):
  - pc ← RESET_VECTOR; pc_valid ← 0; flush ← 0; misalign_err ← 0.
  - RAS count ← 0, so ras_empty=1 and ras_full=0.
  - First edge with rst=1 sets pc_valid ← 1 and keeps pc = RESET_VECTOR; other inputs are ignored that edge.
  - Reset mid-operation discards all RAS contents.
- Arithmetic:
  - pc_plus = pc + INSTR_BYTES, modulo 2^XLEN; wraps silently (e.g. FFFF_FFFC+4 = 0).
- Next-PC priority, evaluated each edge while pc_valid=1:
  1. trap: pc ← trap_vector; flush ← 1; RAS unchanged.
  2. redir_valid, kind JUMP: pc ← aligned(redir_target); flush ← 1.
  3. redir_valid, kind CALL: push pc_plus onto RAS; pc ← aligned(redir_target); flush ← 1.
  4. redir_valid, kind RET: if RAS non-empty, pop and pc ← popped value; if empty, pc ← aligned(redir_target). flush ← 1 either way.
  5. stall: pc holds; flush ← 0.
  6. Otherwise: pc ← pc_plus; flush ← 0.
- Redirect and trap override stall; stall never drops a redirect.
- Trap and redir_valid in the same cycle: trap wins, the redirect is discarded, no RAS push or pop.
- Alignment:
  - aligned(x) clears the low log2(INSTR_BYTES) bits.
  - misalign_err ← 1 for one cycle if an applied JUMP/CALL target (or RET fallback target) had nonzero low bits.
  - trap_vector is not checked; it is used as given.
- RAS:
  - Circular buffer with top pointer and count.
  - Push when full: overwrite the oldest entry; count stays RAS_DEPTH; ras_full stays 1.
  - Pop decrements count. No push and pop in the same cycle (CALL and RET are mutually exclusive).
- Latency:
  - Redirect is visible on pc the cycle after request.
  - flush is asserted in the same cycle as the new pc.

Decomposition:
- pc_pkg holds:
  - typedef enum logic [1:0] redir_e {JUMP=0, CALL=1, RET=2}; value 3 is reserved and treated as JUMP.
  - Helper localparam for ALIGN_BITS.
- One sub-module, pc_ras: parametrised on XLEN and RAS_DEPTH.
  - Ports: clk, rst, push, push_data, pop, top, empty, full.
  - pop while empty is a no-op.
- pc_unit instantiates pc_ras and owns the PC register and priority mux.

Test Plan:
- Reset then release, no stimulus → pc=0000_0000, pc_valid=0 during reset; then pc advances 0, 4, 8, 0C on successive cycles; pc_plus=pc+4 each cycle.
- stall=1 for 3 cycles at pc=0000_0010 → pc holds 0000_0010, flush=0; after release, pc=0000_0014.
- CALL, redir_target=0000_0100, issued at pc=0000_0020 → next pc=0000_0100, flush=1. A later RET with redir_target=0000_0FFF returns pc=0000_0024 from the RAS; ras_empty returns to 1.
- 5 CALLs with RAS_DEPTH=4 → ras_full=1 after the 4th. Four RETs return the 4 newest return addresses in LIFO order. A 5th RET uses fallback redir_target; misalign_err pulses if that target is unaligned, e.g. 0000_0202 → pc=0000_0200.
- trap=1 with trap_vector=0000_0080, plus redir_valid JUMP to 0000_0300 and stall=1 in the same cycle → pc=0000_0080, flush=1, RAS count unchanged.
- pc=FFFF_FFFC with no stall → next pc=0000_0000. rst=0 asserted mid-sequence with RAS non-empty → pc=RESET_VECTOR, ras_empty=1.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter unit.
package pc_pkg;

  // Redirect request kinds; encoding 2'd3 is reserved and behaves as JUMP.
  typedef enum logic [1:0] {
    JUMP = 2'd0,
    CALL = 2'd1,
    RET  = 2'd2
  } redir_e;

  // Default sequential increment and the number of low address bits it implies.
  localparam int DEFAULT_INSTR_BYTES = 4;
  localparam int ALIGN_BITS          = $clog2(DEFAULT_INSTR_BYTES);

  // Number of low bits cleared by alignment for a given instruction size.
  function automatic int align_bits(input int instr_bytes);
    return $clog2(instr_bytes);
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer with a top pointer and an entry count.
// A push when full overwrites the oldest entry; a pop when empty does nothing.
module pc_ras #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [XLEN-1:0] push_data,
  input  logic            pop,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);

  logic [PTR_W-1:0] top_q, top_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  mem_q [RAS_DEPTH];
  logic [XLEN-1:0]  mem_d [RAS_DEPTH];
  logic [PTR_W-1:0] wr_ptr_s;

  assign wr_ptr_s = top_q + PTR_W'(1);

  // Next pointer, count and storage for a push or a non-empty pop.
  always_comb begin
    top_d = top_q;
    cnt_d = cnt_q;
    mem_d = mem_q;
    if (push) begin
      top_d           = wr_ptr_s;
      mem_d[wr_ptr_s] = push_data;
      if (cnt_q != DEPTH_C) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else if (pop && (cnt_q != {CNT_W{1'b0}})) begin
      top_d = top_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      top_d = top_q;
    end
  end

  // Stack state registers; reset empties the stack and clears storage.
  always_ff @(posedge clk) begin
    if (!rst) begin
      top_q <= {PTR_W{1'b0}};
      cnt_q <= {CNT_W{1'b0}};
      for (int i = 0; i < RAS_DEPTH; i++) begin
        mem_q[i] <= {XLEN{1'b0}};
      end
    end else begin
      top_q <= top_d;
      cnt_q <= cnt_d;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign top   = mem_q[top_q];
  assign empty = (cnt_q == {CNT_W{1'b0}});
  assign full  = (cnt_q == DEPTH_C);

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: PC register, PC+step adder, priority next-PC
// selection (trap > redirect > stall > sequential) and return prediction.
module pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter int              INSTR_BYTES  = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redir_valid,
  input  redir_e          redir_kind,
  input  logic [XLEN-1:0] redir_target,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vector,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus,
  output logic            pc_valid,
  output logic            flush,
  output logic            misalign_err,
  output logic            ras_empty,
  output logic            ras_full
);

  localparam int              A_BITS   = align_bits(INSTR_BYTES);
  localparam logic [XLEN-1:0] LOW_MASK = ~({XLEN{1'b1}} << A_BITS);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            pc_valid_q, pc_valid_d;
  logic            flush_q, flush_d;
  logic            misalign_q, misalign_d;
  logic            ras_push_s, ras_pop_s;
  logic [XLEN-1:0] ras_top_s;
  logic [XLEN-1:0] target_aligned_s;
  logic            target_misaligned_s;

  assign pc_plus             = pc_q + XLEN'(INSTR_BYTES);
  assign target_aligned_s    = redir_target & ~LOW_MASK;
  assign target_misaligned_s = |(redir_target & LOW_MASK);

  pc_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push_s),
    .push_data (pc_plus),
    .pop       (ras_pop_s),
    .top       (ras_top_s),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  // Next-PC priority mux and RAS push/pop requests.
  always_comb begin
    pc_d       = pc_q;
    pc_valid_d = pc_valid_q;
    flush_d    = 1'b0;
    misalign_d = 1'b0;
    ras_push_s = 1'b0;
    ras_pop_s  = 1'b0;
    if (!pc_valid_q) begin
      // First cycle out of reset: become valid at the reset vector.
      pc_valid_d = 1'b1;
    end else if (trap) begin
      pc_d    = trap_vector;
      flush_d = 1'b1;
    end else if (redir_valid) begin
      flush_d = 1'b1;
      case (redir_kind)
        CALL: begin
          ras_push_s = 1'b1;
          pc_d       = target_aligned_s;
          misalign_d = target_misaligned_s;
        end
        RET: begin
          if (!ras_empty) begin
            ras_pop_s = 1'b1;
            pc_d      = ras_top_s;
          end else begin
            pc_d       = target_aligned_s;
            misalign_d = target_misaligned_s;
          end
        end
        default: begin
          pc_d       = target_aligned_s;
          misalign_d = target_misaligned_s;
        end
      endcase
    end else if (stall) begin
      pc_d = pc_q;
    end else begin
      pc_d = pc_plus;
    end
  end

  // Architectural PC and status pulse registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q       <= RESET_VECTOR;
      pc_valid_q <= 1'b0;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
      flush_q    <= flush_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc           = pc_q;
  assign pc_valid     = pc_valid_q;
  assign flush        = flush_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: driver updates a queue-based reference model
// and pushes expectations; a monitor pops and compares after each clock edge.
module tb_pc_unit;
  import pc_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redir_valid = 1'b0;
  redir_e      redir_kind = JUMP;
  logic [31:0] redir_target = 32'h0;
  logic        trap = 1'b0;
  logic [31:0] trap_vector = 32'h0;
  logic [31:0] pc, pc_plus;
  logic        pc_valid, flush, misalign_err, ras_empty, ras_full;

  pc_unit #(
    .XLEN(32), .INSTR_BYTES(4), .RESET_VECTOR(32'h0000_0000), .RAS_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .redir_valid(redir_valid),
    .redir_kind(redir_kind), .redir_target(redir_target), .trap(trap),
    .trap_vector(trap_vector), .pc(pc), .pc_plus(pc_plus), .pc_valid(pc_valid),
    .flush(flush), .misalign_err(misalign_err), .ras_empty(ras_empty),
    .ras_full(ras_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic        flush;
    logic        mis;
    logic        empty;
    logic        full;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  // Reference model state: plain PC value and return addresses as a queue.
  logic [31:0] m_pc = 32'h0;
  logic        m_valid = 1'b0;
  logic        m_flush = 1'b0;
  logic        m_mis = 1'b0;
  logic [31:0] m_ras[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Apply one cycle of stimulus and advance the reference model.
  task automatic cyc(input logic r, input logic st, input logic rv, input logic [1:0] k,
                     input logic [31:0] tgt, input logic tr, input logic [31:0] tv);
    exp_t e;
    @(negedge clk);
    rst = r; stall = st; redir_valid = rv; redir_kind = redir_e'(k);
    redir_target = tgt; trap = tr; trap_vector = tv;
    m_flush = 1'b0;
    m_mis   = 1'b0;
    if (!r) begin
      m_pc = 32'h0; m_valid = 1'b0; m_ras.delete();
    end else if (!m_valid) begin
      m_valid = 1'b1;
    end else if (tr) begin
      m_pc = tv; m_flush = 1'b1;
    end else if (rv) begin
      m_flush = 1'b1;
      if (k == 2'd2 && m_ras.size() > 0) begin
        m_pc = m_ras.pop_back();
      end else begin
        if (k == 2'd1) begin
          m_ras.push_back(m_pc + 32'd4);
          if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        end
        m_mis = (tgt % 32'd4) != 32'd0;
        m_pc  = tgt - (tgt % 32'd4);
      end
    end else if (!st) begin
      m_pc = m_pc + 32'd4;
    end
    e.pc = m_pc; e.valid = m_valid; e.flush = m_flush; e.mis = m_mis;
    e.empty = (m_ras.size() == 0);
    e.full  = (m_ras.size() == DEPTH);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic redir(input logic [1:0] k, input logic [31:0] tgt);
    cyc(1'b1, 1'b0, 1'b1, k, tgt, 1'b0, 32'h0);
  endtask

  // Monitor: compare the DUT against the oldest expectation after every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pc", pc, e.pc);
        check("pc_plus", pc_plus, e.pc + 32'd4);
        check("pc_valid", {31'b0, pc_valid}, {31'b0, e.valid});
        check("flush", {31'b0, flush}, {31'b0, e.flush});
        check("misalign_err", {31'b0, misalign_err}, {31'b0, e.mis});
        check("ras_empty", {31'b0, ras_empty}, {31'b0, e.empty});
        check("ras_full", {31'b0, ras_full}, {31'b0, e.full});
      end
    end
  end

  // Driver: directed scenarios followed by randomized traffic.
  initial begin
    logic [31:0] tgt;
    int          r;
    // Reset, release, sequential advance up to 0x10.
    cyc(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 32'h0);
    idle(5);
    // Stall three cycles at 0x10, then resume to 0x14 .. 0x20.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 2'd0, 32'h0, 1'b0, 32'h0);
    idle(4);
    // CALL from 0x20 then RET with an unused unaligned fallback.
    redir(2'd1, 32'h0000_0100);
    redir(2'd2, 32'h0000_0FFF);
    // Five CALLs overflow the stack, five RETs drain it and hit the fallback.
    for (int i = 1; i <= 5; i++) redir(2'd1, 32'h0000_1000 * i);
    for (int i = 0; i < 4; i++) redir(2'd2, 32'h0000_0F00);
    redir(2'd2, 32'h0000_0202);
    idle(1);
    // Trap beats a simultaneous JUMP and stall; RAS untouched.
    redir(2'd1, 32'h0000_0400);
    cyc(1'b1, 1'b1, 1'b1, 2'd0, 32'h0000_0300, 1'b1, 32'h0000_0080);
    // Trap vector is used unaligned; reserved kind behaves as JUMP.
    cyc(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 32'h0000_0093);
    redir(2'd3, 32'h0000_0501);
    // Wrap at the top of the address space.
    redir(2'd0, 32'hFFFF_FFFC);
    idle(2);
    // Reset in the middle of activity with the stack non-empty.
    redir(2'd1, 32'h0000_0600);
    redir(2'd1, 32'h0000_0700);
    cyc(1'b0, 1'b0, 1'b1, 2'd2, 32'h0, 1'b0, 32'h0);
    idle(2);
    redir(2'd2, 32'h0000_0808);
    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      tgt = ($urandom_range(0, 3) == 0) ? $urandom : (32'h0000_0100 * $urandom_range(0, 63) + $urandom_range(0, 3));
      cyc((r < 2) ? 1'b0 : 1'b1,
          ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 2) == 0),
          2'($urandom_range(0, 3)),
          tgt,
          ($urandom_range(0, 15) == 0),
          $urandom);
    end
    idle(2);
    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
